// File: rtl/ifetch_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ifetch_responder
// Purpose : single-outstanding instruction fetch engine with fixed-latency
//           memory, alignment/range error responses and flush support.
// Rev     : 1.0
// ============================================================================
module ifetch_responder #(
  parameter int LATENCY = 1,  // 1..7
  parameter int MEM_AW  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic [31:0]       resp_pc,
  output logic              resp_err
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q,    pc_d;
  logic             err_q,   err_d;

  logic hi_zero;
  logic addr_ok;
  logic accept;
  logic last_beat;

  // Upper address bits only exist to check when the memory is narrower
  // than the full 30-bit word space.
  generate
    if (MEM_AW + 2 >= 32) begin : g_full_range
      assign hi_zero = 1'b1;
    end else begin : g_range_chk
      assign hi_zero = (req_addr[31:MEM_AW+2] == '0);
    end
  endgenerate

  assign addr_ok   = (req_addr[1:0] == 2'b00) && hi_zero;
  assign accept    = (state_q == IDLE) && req_valid && !flush;
  assign last_beat = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pc_d = req_addr;
          if (addr_ok) begin
            cnt_d   = LAT_INIT;
            state_d = WAIT;
          end else begin
            instr_d = 32'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // A flush landing on the data cycle has nothing left to drain.
        if (flush) begin
          state_d = last_beat ? IDLE : DROP;
        end else if (last_beat) begin
          instr_d = mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end

      RESP: begin
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end

      DROP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Strobe is qualified with rst_n so no read escapes while reset is held.
  assign req_ready  = (state_q == IDLE);
  assign mem_en     = accept && addr_ok && rst_n;
  assign mem_addr   = req_addr[MEM_AW+1:2];
  assign resp_valid = (state_q == RESP);
  assign resp_instr = instr_q;
  assign resp_pc    = pc_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: doc/ifetch_responder.md
IFETCH_RESPONDER -- requirements
Module: ifetch_responder

Interface
REQ-001 Parameter LATENCY, default 1: cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..7.
REQ-002 Parameter MEM_AW, default 14: instruction memory word-address width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  fetch request from the PC stage.
REQ-006 req_addr  input  32  byte address of the requested instruction (PC value).
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 flush  input  1  branch/redirect; discard any in-flight or pending fetch.
REQ-009 mem_en  output  1  one-cycle read strobe to instruction memory.
REQ-010 mem_addr  output  MEM_AW  word address, equal to req_addr[MEM_AW+1:2].
REQ-011 mem_rdata  input  32  memory read data.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_instr  output  32  fetched instruction.
REQ-015 resp_pc  output  32  byte address the response belongs to.
REQ-016 resp_err  output  1  request was misaligned or out of range.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP, DROP; req_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL be req_valid & req_ready & ~flush in a cycle; flush in IDLE blocks acceptance that cycle.
REQ-019 Accepted address with req_addr[1:0]!=0 or req_addr[31:MEM_AW+2]!=0: no mem_en; latch resp_pc=req_addr, resp_instr=0, resp_err=1; go to RESP.
REQ-020 Accepted legal address: mem_en=1 and mem_addr driven combinationally in the acceptance cycle only; latch resp_pc; load wait counter with LATENCY; go to WAIT.
REQ-021 WAIT: counter SHALL decrement each cycle; in the cycle it reaches the mem_rdata-valid cycle (acceptance cycle + LATENCY), capture mem_rdata into resp_instr with resp_err=0 and go to RESP.
REQ-022 Legal-fetch latency: acceptance in cycle T SHALL give resp_valid in cycle T+LATENCY+1; error latency SHALL be resp_valid in cycle T+1.
REQ-023 RESP: resp_valid=1; resp_instr, resp_pc and resp_err SHALL hold stable until resp_valid & resp_ready; then go to IDLE.
REQ-024 flush in WAIT: go to DROP; DROP SHALL continue counting, discard mem_rdata, and go to IDLE without asserting resp_valid.
REQ-025 flush in RESP: resp_valid SHALL deassert next cycle, go to IDLE; flush SHALL take precedence over a simultaneous resp_ready.
REQ-026 flush in DROP SHALL have no additional effect.
REQ-027 mem_en SHALL never assert outside IDLE; at most one fetch outstanding.
REQ-028 Back-to-back: after a handshake in cycle N the next request SHALL be acceptable in cycle N+1.
REQ-029 The PC stage updates on the falling edge; req_addr SHALL be sampled only on the rising edge.

Reset
REQ-030 reset low SHALL asynchronously force state IDLE, counter 0, resp_valid 0, resp_instr 0, resp_pc 0, resp_err 0, mem_en 0.
REQ-031 Reset mid-WAIT or mid-RESP SHALL discard the transaction; the late mem_rdata SHALL be ignored.
REQ-032 After reset release, req_ready SHALL be 1 in the first cycle.

Verification
REQ-033 LATENCY=1, req_addr=0x00000004 accepted cycle 0, mem_rdata=0x00A00093 in cycle 1 -> mem_en=1, mem_addr=1 in cycle 0; resp_valid, resp_instr=0x00A00093, resp_pc=0x4, resp_err=0 in cycle 2.
REQ-034 req_addr=0x00000006 -> no mem_en; resp_valid cycle 1, resp_err=1, resp_instr=0, resp_pc=0x6.
REQ-035 MEM_AW=14, req_addr=0x00010000 -> resp_err=1, no mem_en.
REQ-036 LATENCY=3, flush in cycle 1 after acceptance -> no resp_valid; req_ready=1 in cycle 4; new request at 0x8 completes normally.
REQ-037 resp_ready held 0 for 5 cycles in RESP -> outputs stable; resp_ready=1 with flush=1 -> no handshake, IDLE next cycle.
REQ-038 reset low during WAIT -> all outputs 0 immediately; stale mem_rdata never appears on resp_instr.
